fwrisc_mds_ct: RTL and testbench
================================

FWRISC_MDS_CT -- requirements
Module: fwrisc_mds_ct

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 32 bits.
REQ-002 The block SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-low; clock clk.
REQ-004 The block SHALL have port in_a  input  32  operand A (value shifted, multiplicand, dividend).
REQ-005 The block SHALL have port in_b  input  32  operand B (shift amount in bits [4:0], multiplier, divisor).
REQ-006 The block SHALL have port op  input  4  operation: 0 SLL, 1 SRL, 2 SRA, 3 MUL, 4 MULH, 5 MULS, 6 MULSH, 7 DIV, 8 REM, 9..15 NOP.
REQ-007 The block SHALL have port in_valid  input  1  request strobe, sampled only when busy==0.
REQ-008 The block SHALL have port busy  output  1  high while an accepted operation is in flight.
REQ-009 The block SHALL have port out  output  32  result register.
REQ-010 The block SHALL have port out_valid  output  1  one-cycle pulse marking out as valid.

Function
REQ-011 The block SHALL be the constant-time responder for the mul/div/shift request protocol: latency SHALL be independent of in_a, in_b and op, including NOP.
REQ-012 FSM states SHALL be IDLE, BUSY and DONE; IDLE->BUSY on in_valid; BUSY->DONE when the iteration counter reaches 31; DONE->BUSY if in_valid, else DONE->IDLE.
REQ-013 A request SHALL be accepted at the rising edge at which in_valid==1 and the state is IDLE or DONE; operands and op SHALL be captured into internal registers at acceptance.
REQ-014 busy SHALL be 1 exactly in BUSY; in_valid while BUSY SHALL be ignored and SHALL NOT alter the captured operands.
REQ-015 If a request is accepted at edge T, BUSY SHALL span the 32 cycles after T, and out_valid SHALL be 1 for exactly the single cycle after edge T+33; out SHALL update at that same edge.
REQ-016 The 5-bit iteration counter SHALL clear on acceptance, increment every BUSY cycle and wrap 31->0.
REQ-017 Every op SHALL execute 32 iterations, with no early termination on zero operands, small divisors or NOP.
REQ-018 SLL/SRL/SRA SHALL shift in_a by in_b[4:0]; in_b[31:5] SHALL be ignored; SRA SHALL replicate bit 31.
REQ-019 MUL SHALL return product[31:0] and MULH SHALL return product[63:32] of unsigned x unsigned.
REQ-020 MULS SHALL return product[31:0] and MULSH SHALL return product[63:32] of signed x signed.
REQ-021 Multiplies SHALL use a 32-step shift-add on magnitudes followed by conditional two's-complement negation of the 64-bit product.
REQ-022 DIV/REM SHALL be signed, using 32-step restoring division on magnitudes; the quotient sign SHALL be the XOR of the operand signs, and the remainder SHALL take the dividend's sign.
REQ-023 For divide by zero, DIV SHALL return 0xFFFFFFFF and REM SHALL return in_a, after the full 32-step latency.
REQ-024 For 0x80000000 / 0xFFFFFFFF, DIV SHALL return 0x80000000 and REM SHALL return 0x00000000, after the full latency.
REQ-025 NOP SHALL return out = 0x00000000 with the same out_valid timing.
REQ-026 out SHALL hold its value until the next out_valid edge.
REQ-027 A request accepted in DONE (back-to-back) SHALL produce its out_valid exactly 33 cycles after its acceptance edge.

Reset
REQ-028 When rst==0 at a rising edge, the FSM SHALL enter IDLE and busy, out_valid, out, the counter and all datapath registers SHALL be cleared to 0.
REQ-029 A reset during BUSY or DONE SHALL abort the operation; no out_valid SHALL be produced for the aborted request.
REQ-030 A request presented at the first edge with rst==1 SHALL be accepted normally.
REQ-031 Reset SHALL take priority over in_valid at the same edge.

Verification
REQ-032 op=3, a=7, b=6, accepted at T -> out=0x0000002A with out_valid high only in the cycle after T+33; op=4, a=b=0xFFFFFFFF -> out=0xFFFFFFFE.
REQ-033 op=6, a=0x80000000, b=2 -> out=0xFFFFFFFF; op=7, a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; op=8 with the same operands -> 0xFFFFFFFF.
REQ-034 op=7/8, a=5, b=0 -> out=0xFFFFFFFF / 0x00000005; op=7/8, a=0x80000000, b=0xFFFFFFFF -> 0x80000000 / 0; each with standard latency.
REQ-035 op=2, a=0x80000000, b=0x24 -> out=0xF8000000; op=12 (NOP) -> out=0 with standard latency.
REQ-036 Run two requests with identical op and differing data (e.g. DIV 1/1 vs 0xFFFFFFFF/3), and also NOP vs MUL -> out_valid SHALL rise in the identical cycle.
REQ-037 Drive rst=0 at T+10 of a DIV -> busy=0 and out=0 from the next cycle, and no out_valid; also drive in_valid during BUSY -> it is ignored and the result matches the first request.

Source files
------------

// File: rtl/fwrisc_mds_ct.sv
// Constant-time multiply / divide / shift unit: every request takes the same
// 32 iterations regardless of op or operand values, then pulses out_valid.
`timescale 1ns/1ps
module fwrisc_mds_ct (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [3:0]  op,
    input  logic        in_valid,
    output logic        busy,
    output logic [31:0] out,
    output logic        out_valid
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    localparam logic [3:0] OP_SLL   = 4'd0;
    localparam logic [3:0] OP_SRL   = 4'd1;
    localparam logic [3:0] OP_SRA   = 4'd2;
    localparam logic [3:0] OP_MUL   = 4'd3;
    localparam logic [3:0] OP_MULH  = 4'd4;
    localparam logic [3:0] OP_MULS  = 4'd5;
    localparam logic [3:0] OP_MULSH = 4'd6;
    localparam logic [3:0] OP_DIV   = 4'd7;
    localparam logic [3:0] OP_REM   = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_accept;
    logic                w_step;
    logic                w_done;

    logic [CW-1:0]       r_cnt;
    logic [3:0]          r_op;
    logic [W-1:0]        r_a;
    logic [W-1:0]        r_b;
    logic [W-1:0]        r_x;
    logic [W-1:0]        r_y;
    logic [2*W-1:0]      r_acc;
    logic                r_sa;
    logic                r_sb;

    logic                w_sgn_in;
    logic                w_div_in;
    logic                w_div_r;
    logic [W-1:0]        w_mag_a;
    logic [W-1:0]        w_mag_b;
    logic [W:0]          w_msum;
    logic [2*W-1:0]      w_dsh;
    logic [W:0]          w_trial;
    logic [2*W-1:0]      w_prod;
    logic [W-1:0]        w_quo;
    logic [W-1:0]        w_rem;
    logic [W-1:0]        w_result;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = BUSY;
            BUSY:    if (r_cnt == CW'(31)) w_next = DONE;
            DONE:    w_next = in_valid ? BUSY : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Per-state control strobes
    always_comb begin
        w_accept = 1'b0;
        w_step   = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            IDLE: w_accept = in_valid;
            BUSY: w_step   = 1'b1;
            DONE: begin
                w_accept = in_valid;
                w_done   = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_sgn_in = (op == OP_MULS) || (op == OP_MULSH) || (op == OP_DIV) || (op == OP_REM);
    assign w_div_in = (op == OP_DIV) || (op == OP_REM);
    assign w_div_r  = (r_op == OP_DIV) || (r_op == OP_REM);
    assign w_mag_a  = (w_sgn_in && in_a[W-1]) ? W'(-in_a) : in_a;
    assign w_mag_b  = (w_sgn_in && in_b[W-1]) ? W'(-in_b) : in_b;

    // Shift-add step: r_acc = {partial hi, multiplier shifting out of lo}
    assign w_msum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_x} : (W+1)'(0));
    // Restoring-division step: r_acc = {remainder, dividend/quotient}
    assign w_dsh   = {r_acc[2*W-2:0], 1'b0};
    assign w_trial = {1'b0, w_dsh[2*W-1:W]} - {1'b0, r_y};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_x   <= '0;
            r_y   <= '0;
            r_acc <= '0;
            r_sa  <= 1'b0;
            r_sb  <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_op  <= op;
            r_a   <= in_a;
            r_b   <= in_b;
            r_x   <= w_mag_a;
            r_y   <= w_mag_b;
            r_acc <= {W'(0), (w_div_in ? w_mag_a : w_mag_b)};
            r_sa  <= w_sgn_in & in_a[W-1];
            r_sb  <= w_sgn_in & in_b[W-1];
        end else if (w_step) begin
            r_cnt <= r_cnt + CW'(1);
            if (w_div_r) begin
                r_acc <= w_trial[W] ? w_dsh : {w_trial[W-1:0], w_dsh[W-1:1], 1'b1};
            end else begin
                r_acc <= {w_msum, r_acc[W-1:1]};
            end
        end
    end

    // Sign fix-up of magnitude results and final op select
    assign w_prod = (r_sa ^ r_sb) ? (2*W)'(-r_acc) : r_acc;
    assign w_quo  = (r_sa ^ r_sb) ? W'(-r_acc[W-1:0]) : r_acc[W-1:0];
    assign w_rem  = r_sa ? W'(-r_acc[2*W-1:W]) : r_acc[2*W-1:W];

    always_comb begin
        w_result = '0;
        case (r_op)
            OP_SLL:   w_result = r_a << r_b[4:0];
            OP_SRL:   w_result = r_a >> r_b[4:0];
            OP_SRA:   w_result = W'($signed(r_a) >>> r_b[4:0]);
            OP_MUL:   w_result = w_prod[W-1:0];
            OP_MULS:  w_result = w_prod[W-1:0];
            OP_MULH:  w_result = w_prod[2*W-1:W];
            OP_MULSH: w_result = w_prod[2*W-1:W];
            OP_DIV:   w_result = (r_b == '0) ? '1 : w_quo;
            OP_REM:   w_result = (r_b == '0) ? r_a : w_rem;
            default:  w_result = '0;
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
        end else begin
            busy      <= (w_next == BUSY);
            out_valid <= w_done;
            if (w_done) begin
                out <= w_result;
            end
        end
    end

endmodule

// File: tb/tb_fwrisc_mds_ct.sv
// Directed bench for fwrisc_mds_ct: results, fixed 33-cycle latency,
// back-to-back issue, ignored requests while busy and reset abort.
`timescale 1ns/1ps
module tb_fwrisc_mds_ct;

    logic        clk;
    logic        rst;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  op;
    logic        in_valid;
    logic        busy;
    logic [31:0] out;
    logic        out_valid;

    int checks;
    int errors;

    fwrisc_mds_ct dut (
        .clk       (clk),
        .rst       (rst),
        .in_a      (in_a),
        .in_b      (in_b),
        .op        (op),
        .in_valid  (in_valid),
        .busy      (busy),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for out_valid; returns edges counted since the acceptance edge.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (out_valid) lat = k;
        end
    endtask

    // Called at a negedge; issues one request and checks latency, result, pulse and hold.
    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
        int lat;
        op = o; in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({31'd0, busy}, 32'd1, {tag, "_busy"});
        wait_valid(lat);
        chk(32'(lat), 32'd33, {tag, "_lat"});
        chk(out, exp, {tag, "_out"});
        @(posedge clk); #1;
        chk({31'd0, out_valid}, 32'd0, {tag, "_pulse"});
        chk(out, exp, {tag, "_hold"});
    endtask

    initial begin
        int lat;
        int nvalid;
        checks = 0;
        errors = 0;
        rst = 1'b0; in_valid = 1'b0; op = 4'd0; in_a = '0; in_b = '0;

        repeat (3) @(posedge clk);
        #1;
        chk({31'd0, busy}, 32'd0, "rst_busy");
        chk({31'd0, out_valid}, 32'd0, "rst_valid");
        chk(out, 32'd0, "rst_out");

        // First edge with rst released also accepts the request
        @(negedge clk); rst = 1'b1;
        do_op(4'd3, 32'd7, 32'd6, 32'h0000002A, "mul");
        @(negedge clk); do_op(4'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulh");
        @(negedge clk); do_op(4'd6, 32'h80000000, 32'd2, 32'hFFFFFFFF, "mulsh");
        @(negedge clk); do_op(4'd5, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, "muls");
        @(negedge clk); do_op(4'd7, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div_neg");
        @(negedge clk); do_op(4'd8, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem_neg");
        @(negedge clk); do_op(4'd7, 32'd5, 32'd0, 32'hFFFFFFFF, "div_zero");
        @(negedge clk); do_op(4'd8, 32'd5, 32'd0, 32'h00000005, "rem_zero");
        @(negedge clk); do_op(4'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
        @(negedge clk); do_op(4'd8, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_ovf");
        @(negedge clk); do_op(4'd2, 32'h80000000, 32'h00000024, 32'hF8000000, "sra");
        @(negedge clk); do_op(4'd0, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, "sll");
        @(negedge clk); do_op(4'd1, 32'h80000000, 32'd31, 32'h00000001, "srl");
        @(negedge clk); do_op(4'd12, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, "nop");
        @(negedge clk); do_op(4'd7, 32'd1, 32'd1, 32'h00000001, "div_1_1");
        @(negedge clk); do_op(4'd7, 32'hFFFFFFFF, 32'd3, 32'h00000000, "div_m1_3");
        @(negedge clk); do_op(4'd3, 32'h0001_0000, 32'h0001_0000, 32'h00000000, "mul_lo0");

        // in_valid held through BUSY is ignored, then accepted in DONE
        @(negedge clk);
        op = 4'd3; in_a = 32'd7; in_b = 32'd6; in_valid = 1'b1;
        @(posedge clk); #1;
        op = 4'd7; in_a = 32'd100; in_b = 32'd7;
        wait_valid(lat);
        in_valid = 1'b0;
        chk(32'(lat), 32'd33, "b2b_lat1");
        chk(out, 32'h0000002A, "b2b_out1");
        chk({31'd0, busy}, 32'd1, "b2b_busy");
        wait_valid(lat);
        chk(32'(lat), 32'd33, "b2b_lat2");
        chk(out, 32'd14, "b2b_out2");

        // Reset 10 edges into a DIV aborts it
        @(negedge clk);
        op = 4'd7; in_a = 32'd100; in_b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk({31'd0, busy}, 32'd0, "abort_busy");
        chk(out, 32'd0, "abort_out");
        chk({31'd0, out_valid}, 32'd0, "abort_valid");
        @(negedge clk); rst = 1'b1;
        nvalid = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) nvalid++;
        end
        chk(32'(nvalid), 32'd0, "abort_no_valid");

        // Reset wins over a simultaneous request
        @(negedge clk); rst = 1'b0; in_valid = 1'b1; op = 4'd3; in_a = 32'd2; in_b = 32'd3;
        @(posedge clk); #1;
        chk({31'd0, busy}, 32'd0, "rst_prio_busy");
        @(negedge clk); rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk({31'd0, busy}, 32'd0, "rst_prio_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
